// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: cpu stores fill a TX FIFO that a
// bit-serial FSM drains onto tx; loads return status/divisor one cycle later.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wr,
   input  logic [3:0]  data_wr_en,
   output logic [31:0] data_rd,
   output logic        tx,
   output logic        irq_empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bc_q, bc_d;
   logic [7:0]  byte_q, byte_d;
   logic [15:0] div_eff_q, div_eff_d;
   logic        tx_q, tx_d;
   logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic        overflow_q, overflow_d;
   logic [15:0] div_q, div_d;
   logic [31:0] rd_q, rd_d;
   logic [7:0]  mem_q [FIFO_DEPTH];

   logic        sel, push_req, push_ok, pop, ovf_clr;
   logic [1:0]  offset;
   logic        empty, full, busy;
   logic [15:0] div_sel;
   logic        unused_ok;

   assign unused_ok = ^{data_addr[1:0], data_wr[31:16], data_wr_en[3:2]};

   always_comb begin
      sel      = (data_addr[31:4] == BASE_ADDR[31:4]);
      offset   = data_addr[3:2];
      empty    = (wptr_q == rptr_q);
      full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      busy     = (state_q != S_IDLE);
      // Full is judged before any same-cycle pop, so such a push is dropped.
      push_req = sel && (offset == 2'd0) && data_wr_en[0];
      push_ok  = push_req && !full;
      ovf_clr  = sel && (offset == 2'd1) && data_wr_en[0] && data_wr[3];
      div_sel  = (div_q < 16'd2) ? 16'd2 : div_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bc_d      = bc_q;
      byte_d    = byte_q;
      div_eff_d = div_eff_q;
      tx_d      = tx_q;
      pop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop       = 1'b1;
               byte_d    = mem_q[rptr_q[AW-1:0]];
               div_eff_d = div_sel;
               cnt_d     = div_sel - 16'd1;
               tx_d      = 1'b0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (cnt_q == 16'd0) begin
               tx_d    = byte_q[0];
               bc_d    = 3'd0;
               cnt_d   = div_eff_q - 16'd1;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (cnt_q == 16'd0) begin
               cnt_d = div_eff_q - 16'd1;
               if (bc_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bc_d = bc_q + 3'd1;
                  tx_d = byte_q[bc_q + 3'd1];
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (cnt_q == 16'd0) begin
               // Chain straight into the next start bit to avoid an idle gap.
               if (!empty) begin
                  pop       = 1'b1;
                  byte_d    = mem_q[rptr_q[AW-1:0]];
                  div_eff_d = div_sel;
                  cnt_d     = div_sel - 16'd1;
                  tx_d      = 1'b0;
                  state_d   = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_comb begin
      wptr_d     = wptr_q + {{AW{1'b0}}, push_ok};
      rptr_d     = rptr_q + {{AW{1'b0}}, pop};
      overflow_d = overflow_q;
      if (push_req && full) overflow_d = 1'b1;
      else if (ovf_clr)     overflow_d = 1'b0;
      div_d = div_q;
      if (sel && (offset == 2'd2)) begin
         if (data_wr_en[0]) div_d[7:0]  = data_wr[7:0];
         if (data_wr_en[1]) div_d[15:8] = data_wr[15:8];
      end
      rd_d = 32'h0;
      if (sel) begin
         case (offset)
            2'd1:    rd_d = {28'h0, overflow_q, busy, empty, full};
            2'd2:    rd_d = {16'h0, div_q};
            default: rd_d = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         bc_q       <= 3'd0;
         byte_q     <= 8'd0;
         div_eff_q  <= 16'd2;
         tx_q       <= 1'b1;
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
         div_q      <= DEFAULT_DIV;
         rd_q       <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bc_q       <= bc_d;
         byte_q     <= byte_d;
         div_eff_q  <= div_eff_d;
         tx_q       <= tx_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         overflow_q <= overflow_d;
         div_q      <= div_d;
         rd_q       <= rd_d;
      end
   end

   // FIFO storage needs no reset; pointers alone define its contents.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q[AW-1:0]] <= data_wr[7:0];
   end

   assign data_rd   = rd_q;
   assign tx        = tx_q;
   assign irq_empty = empty && !busy;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, frame timing, FIFO overflow,
// divisor handling and byte-lane decoding.
module tb_uart_tx_mmio;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int LOGN = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data_addr = 32'h0;
   logic [31:0] data_wr = 32'h0;
   logic [3:0]  data_wr_en = 4'h0;
   logic [31:0] data_rd;
   logic        tx;
   logic        irq_empty;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic tx_log [LOGN];

   uart_tx_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
      .clk(clk), .rst(rst), .data_addr(data_addr), .data_wr(data_wr),
      .data_wr_en(data_wr_en), .data_rd(data_rd), .tx(tx), .irq_empty(irq_empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // tx_log[n] holds tx as seen after the n-th rising edge
   always @(negedge clk) tx_log[cyc % LOGN] <= tx;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
      data_addr = a; data_wr = d; data_wr_en = en;
      @(posedge clk); @(negedge clk);
      data_addr = 32'h0; data_wr = 32'h0; data_wr_en = 4'h0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      data_addr = a;
      @(posedge clk); @(negedge clk);
      v = data_rd;
      data_addr = 32'h0;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic check_frame(input int start, input logic [7:0] b, input int div, input string name);
      logic [9:0] fr;
      int bad;
      fr  = {1'b1, b, 1'b0};
      bad = -1;
      for (int i = 0; i < 10 * div; i++)
         if (bad < 0 && tx_log[(start + i) % LOGN] !== fr[i / div]) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s: tx at frame clock %0d = %b, required %b", name, bad,
                  tx_log[(start + bad) % LOGN], fr[bad / div]);
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      repeat (2) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || data_rd !== 32'h0 || irq_empty !== 1'b1) begin
         errors++;
         $display("FAIL reset_outputs: tx=%b rd=%h irq=%b, required 1 00000000 1", tx, data_rd, irq_empty);
      end
      rst = 1'b0;
      @(negedge clk);
      wr(BASE, 32'h00, 4'h1);
      wr(BASE, 32'h55, 4'h1);
      wr(BASE, 32'h66, 4'h1);
      repeat (5) @(negedge clk);
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL midframe_start: tx=%b, required 0", tx);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || irq_empty !== 1'b1 || data_rd !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: tx=%b irq=%b rd=%h, required 1 1 00000000", tx, irq_empty, data_rd);
      end
      @(negedge clk);
      rst = 1'b0;
      rd(BASE + 32'h4, v);
      checks++;
      if (v !== 32'h2) begin
         errors++;
         $display("FAIL reset_status: read %h, required 00000002", v);
      end
      rd(BASE + 32'h8, v);
      checks++;
      if (v !== 32'd434) begin
         errors++;
         $display("FAIL reset_divisor: read %0d, required 434", v);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || irq_empty !== 1'b1) begin
         errors++;
         $display("FAIL fifo_flushed: tx=%b irq=%b, required 1 1", tx, irq_empty);
      end
   endtask

   task automatic test_read();
      logic [31:0] addrs [8] = '{BASE + 32'h8, BASE + 32'hC, BASE + 32'h4, 32'h0,
                                  BASE + 32'h8, BASE, BASE + 32'h8, BASE + 32'h18};
      logic [31:0] exps [8] = '{32'd434, 32'h0, 32'h2, 32'h0, 32'd434, 32'h0, 32'd434, 32'h0};
      data_addr = 32'h0;
      @(negedge clk);
      data_addr = BASE + 32'h8;
      #1;
      checks++;
      if (data_rd !== 32'h0) begin
         errors++;
         $display("FAIL read_latency: rd=%h before edge, required 00000000", data_rd);
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         data_addr = addrs[i];
         @(posedge clk); @(negedge clk);
         checks++;
         if (data_rd !== exps[i]) begin
            errors++;
            $display("FAIL read_%0d addr=%h: rd=%h, required %h", i, addrs[i], data_rd, exps[i]);
         end
      end
      data_addr = 32'h0;
   endtask

   task automatic test_frame();
      int c;
      wr(BASE + 32'h8, 32'd4, 4'h3);
      wr(BASE, 32'hA5, 4'h1);
      c = cyc;
      checks++;
      if (tx !== 1'b1 || irq_empty !== 1'b0) begin
         errors++;
         $display("FAIL frame_push: tx=%b irq=%b, required 1 0", tx, irq_empty);
      end
      wait_cyc(c + 40);
      checks++;
      if (irq_empty !== 1'b0) begin
         errors++;
         $display("FAIL frame_irq_early: irq=%b at clk 40, required 0", irq_empty);
      end
      wait_cyc(c + 41);
      checks++;
      if (irq_empty !== 1'b1) begin
         errors++;
         $display("FAIL frame_irq_end: irq=%b at clk 41, required 1", irq_empty);
      end
      wait_cyc(c + 42);
      check_frame(c + 1, 8'hA5, 4, "frame_a5_div4");
   endtask

   task automatic test_overflow();
      logic [7:0] b [10] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h33, 8'hCC, 8'h7E, 8'h99};
      logic [31:0] v;
      int c0;
      wr(BASE + 32'h8, 32'd2, 4'h3);
      data_addr = BASE; data_wr_en = 4'h1;
      for (int i = 0; i < 10; i++) begin
         data_wr = {24'h0, b[i]};
         @(posedge clk); @(negedge clk);
         if (i == 0) c0 = cyc;
      end
      data_addr = 32'h0; data_wr = 32'h0; data_wr_en = 4'h0;
      rd(BASE + 32'h4, v);
      checks++;
      if (v !== 32'hD) begin
         errors++;
         $display("FAIL ovf_status: read %h, required 0000000d", v);
      end
      wr(BASE + 32'h4, 32'h7, 4'h1);
      rd(BASE + 32'h4, v);
      checks++;
      if (v !== 32'hD) begin
         errors++;
         $display("FAIL ovf_noclear: read %h, required 0000000d", v);
      end
      wr(BASE + 32'h4, 32'h8, 4'h1);
      rd(BASE + 32'h4, v);
      checks++;
      if (v !== 32'h5) begin
         errors++;
         $display("FAIL ovf_clear: read %h, required 00000005", v);
      end
      wait_cyc(c0 + 181);
      checks++;
      if (irq_empty !== 1'b1 || tx !== 1'b1) begin
         errors++;
         $display("FAIL burst_idle: irq=%b tx=%b after 9 frames, required 1 1", irq_empty, tx);
      end
      wait_cyc(c0 + 183);
      for (int j = 0; j < 9; j++)
         check_frame(c0 + 1 + 20 * j, b[j], 2, $sformatf("burst_frame_%0d", j));
   endtask

   task automatic test_divisor();
      logic [31:0] v;
      int c;
      wr(BASE + 32'h8, 32'd0, 4'h3);
      rd(BASE + 32'h8, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL div_zero_readback: read %h, required 00000000", v);
      end
      wr(BASE, 32'h3C, 4'h1);
      c = cyc;
      wr(BASE, 32'hC3, 4'h1);
      wr(BASE + 32'h8, 32'd6, 4'h3);
      wait_cyc(c + 83);
      check_frame(c + 1, 8'h3C, 2, "div0_frame");
      check_frame(c + 21, 8'hC3, 6, "div6_next_frame");
      checks++;
      if (tx_log[(c + 81) % LOGN] !== 1'b1 || irq_empty !== 1'b1) begin
         errors++;
         $display("FAIL div_idle: tx=%b irq=%b, required 1 1", tx_log[(c + 81) % LOGN], irq_empty);
      end
   endtask

   task automatic test_lanes();
      logic [31:0] v;
      int bad;
      wr(BASE, 32'h0000_5555, 4'h2);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (tx !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL lane1_txdata_tx: %0d low samples, required 0", bad);
      end
      rd(BASE + 32'h4, v);
      checks++;
      if (v !== 32'h2) begin
         errors++;
         $display("FAIL lane1_txdata_status: read %h, required 00000002", v);
      end
      wr(BASE + 32'h8, 32'h0000_0100, 4'h2);
      rd(BASE + 32'h8, v);
      checks++;
      if (v !== 32'h106) begin
         errors++;
         $display("FAIL div_lane1: read %h, required 00000106", v);
      end
      wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'hC);
      rd(BASE + 32'h8, v);
      checks++;
      if (v !== 32'h106) begin
         errors++;
         $display("FAIL div_upper_lanes: read %h, required 00000106", v);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_frame();
      test_overflow();
      test_divisor();
      test_lanes();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
